// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer.
// Optional macro PC_MISALIGN_TRAP_EN: trap misaligned PC loads to ERROR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Next_PC,
  input  logic        Redirect,
  input  logic        Stall,
  output logic [31:0] PC_Plus4,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic        Fetch_Err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] instr_n, instr_pc_n;
  logic [31:0] load_pc;
  logic        misalign;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = |Next_PC[1:0];
  assign load_pc  = Next_PC;
`else
  assign misalign = 1'b0;
  assign load_pc  = Next_PC & ~32'h3;
`endif

  assign PC_Plus4    = pc + 32'd4;
  assign Mem_Addr    = pc;
  assign Mem_Req     = (state == REQ);
  assign Instr_Valid = (state == VALID);
  assign Fetch_Err   = (state == ERROR);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    cnt_n      = cnt;
    instr_n    = Instr;
    instr_pc_n = Instr_PC;
    if (Redirect) begin
      cnt_n = 8'd0;
      if (misalign) begin
        state_n = ERROR;
      end else begin
        pc_n    = load_pc;
        state_n = REQ;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (!Stall) state_n = REQ;
        end
        REQ: begin
          if (Mem_Ack) begin
            instr_n    = Mem_RData;
            instr_pc_n = pc;
            cnt_n      = 8'd0;
            state_n    = VALID;
          end else if (cnt == CNT_LAST) begin
            cnt_n   = 8'd0;
            state_n = ERROR;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        VALID: begin
          if (Instr_Ready && !Stall) begin
            if (misalign) begin
              state_n = ERROR;
            end else begin
              pc_n    = load_pc;
              state_n = REQ;
            end
          end
        end
        ERROR: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      cnt      <= 8'd0;
      Instr    <= 32'd0;
      Instr_PC <= 32'd0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      cnt      <= cnt_n;
      Instr    <= instr_n;
      Instr_PC <= instr_pc_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
// Expectations follow PC_MISALIGN_TRAP_EN when it is defined.
module tb_pc_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] Next_PC;
  logic        Redirect;
  logic        Stall;
  logic [31:0] PC_Plus4;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ack;
  logic [31:0] Mem_RData;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic        Fetch_Err;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (15)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Next_PC    (Next_PC),
    .Redirect   (Redirect),
    .Stall      (Stall),
    .PC_Plus4   (PC_Plus4),
    .Mem_Req    (Mem_Req),
    .Mem_Addr   (Mem_Addr),
    .Mem_Ack    (Mem_Ack),
    .Mem_RData  (Mem_RData),
    .Instr      (Instr),
    .Instr_PC   (Instr_PC),
    .Instr_Valid(Instr_Valid),
    .Instr_Ready(Instr_Ready),
    .Fetch_Err  (Fetch_Err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    Next_PC     = 32'd0;
    Redirect    = 1'b0;
    Stall       = 1'b0;
    Mem_Ack     = 1'b0;
    Mem_RData   = 32'd0;
    Instr_Ready = 1'b0;
    #12;
    chk("rst_req",   32'(Mem_Req), 32'd0);
    chk("rst_addr",  Mem_Addr, 32'd0);
    chk("rst_plus4", PC_Plus4, 32'd4);
    chk("rst_valid", 32'(Instr_Valid), 32'd0);
    chk("rst_err",   32'(Fetch_Err), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_ipc",   Instr_PC, 32'd0);
    Reset_n = 1'b1;

    tick();
    chk("f0_req",  32'(Mem_Req), 32'd1);
    chk("f0_addr", Mem_Addr, 32'd0);
    tick();
    chk("f0_wait", 32'(Mem_Req), 32'd1);
    Mem_Ack   = 1'b1;
    Mem_RData = 32'h0050_0093;
    tick();
    Mem_Ack = 1'b0;
    chk("f0_valid", 32'(Instr_Valid), 32'd1);
    chk("f0_instr", Instr, 32'h0050_0093);
    chk("f0_ipc",   Instr_PC, 32'd0);
    chk("f0_noreq", 32'(Mem_Req), 32'd0);
    Instr_Ready = 1'b1;
    Next_PC     = 32'd4;
    tick();
    Instr_Ready = 1'b0;
    chk("f1_addr",  Mem_Addr, 32'd4);
    chk("f1_req",   32'(Mem_Req), 32'd1);
    chk("f1_valid", 32'(Instr_Valid), 32'd0);

    Mem_Ack   = 1'b1;
    Mem_RData = 32'h1111_0001;
    tick();
    Mem_Ack = 1'b0;
    chk("f1_v",     32'(Instr_Valid), 32'd1);
    chk("f1_ipc",   Instr_PC, 32'd4);
    chk("f1_instr", Instr, 32'h1111_0001);
    Instr_Ready = 1'b1;
    Next_PC     = 32'd8;
    tick();
    Instr_Ready = 1'b0;
    chk("f2_addr", Mem_Addr, 32'd8);
    Mem_Ack   = 1'b1;
    Mem_RData = 32'h2222_0002;
    tick();
    Mem_Ack = 1'b0;
    chk("f2_ipc",   Instr_PC, 32'd8);
    chk("f2_instr", Instr, 32'h2222_0002);
    Instr_Ready = 1'b1;
    Next_PC     = 32'd12;
    tick();
    Instr_Ready = 1'b0;
    chk("f3_addr", Mem_Addr, 32'd12);
    Mem_Ack   = 1'b1;
    Mem_RData = 32'h3333_0003;
    tick();
    Mem_Ack = 1'b0;
    chk("f3_ipc", Instr_PC, 32'd12);

    Stall       = 1'b1;
    Instr_Ready = 1'b1;
    Next_PC     = 32'd16;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(Instr_Valid), 32'd1);
      chk("stall_instr", Instr, 32'h3333_0003);
      chk("stall_pc",    Mem_Addr, 32'd12);
    end
    Stall = 1'b0;
    tick();
    Instr_Ready = 1'b0;
    chk("unstall_addr", Mem_Addr, 32'd16);
    chk("unstall_req",  32'(Mem_Req), 32'd1);

    Mem_Ack   = 1'b1;
    Mem_RData = 32'hDEAD_BEEF;
    Redirect  = 1'b1;
    Next_PC   = 32'h100;
    tick();
    Mem_Ack  = 1'b0;
    Redirect = 1'b0;
    chk("rd_addr",  Mem_Addr, 32'h100);
    chk("rd_valid", 32'(Instr_Valid), 32'd0);
    chk("rd_instr", Instr, 32'h3333_0003);
    chk("rd_req",   32'(Mem_Req), 32'd1);

    for (int i = 0; i < 14; i++) tick();
    chk("to_14_err", 32'(Fetch_Err), 32'd0);
    chk("to_14_req", 32'(Mem_Req), 32'd1);
    tick();
    chk("to_err", 32'(Fetch_Err), 32'd1);
    chk("to_req", 32'(Mem_Req), 32'd0);
    tick();
    chk("to_hold", 32'(Fetch_Err), 32'd1);
    Redirect = 1'b1;
    Next_PC  = 32'h40;
    tick();
    Redirect = 1'b0;
    chk("rec_err",  32'(Fetch_Err), 32'd0);
    chk("rec_req",  32'(Mem_Req), 32'd1);
    chk("rec_addr", Mem_Addr, 32'h40);

    Redirect = 1'b1;
    Stall    = 1'b1;
    Next_PC  = 32'hFFFF_FFFC;
    tick();
    Stall = 1'b0;
    chk("wrap_addr",  Mem_Addr, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_Plus4, 32'd0);

    Next_PC = 32'h102;
    tick();
    Redirect = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_err",  32'(Fetch_Err), 32'd1);
    chk("mis_addr", Mem_Addr, 32'hFFFF_FFFC);
`else
    chk("mis_err",  32'(Fetch_Err), 32'd0);
    chk("mis_addr", Mem_Addr, 32'h100);
`endif

    Redirect = 1'b1;
    Next_PC  = 32'h200;
    tick();
    Redirect = 1'b0;
    chk("pre_rst_req", 32'(Mem_Req), 32'd1);
    #2;
    Reset_n   = 1'b0;
    Mem_Ack   = 1'b1;
    Mem_RData = 32'h5555_5555;
    #1;
    chk("arst_req",  32'(Mem_Req), 32'd0);
    chk("arst_addr", Mem_Addr, 32'd0);
    tick();
    Reset_n = 1'b1;
    Mem_Ack = 1'b0;
    tick();
    chk("arst_valid", 32'(Instr_Valid), 32'd0);
    chk("arst_instr", Instr, 32'd0);
    chk("arst_req2",  32'(Mem_Req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
